colsr_frame_loader: RTL and testbench
=====================================

Name: colsr_frame_loader

Overview:
- Parametrised successor to the fixed 26x26 column shift-register front end for the multiplier compressor.
- Serially loads one bit per partial-product column per beat into per-column shift registers with the triangular height profile of an N x N multiplier.
- Presents each completed frame to the compressor as one packed bus, with a valid/ready handshake, backpressure and a frame counter.

Parameters:
- N, 26, operand width. Derived: COLS = 2N-1 columns; column i height h_i = min(i+1, 2N-1-i); TOTAL = N*N packed bits; CW = clog2(N+1).
- FCNT_W, 16, width of the handed-off frame counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat present on in_bits.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_bits  in  COLS  bit i is the serial input for column i.
- flush  in  1  synchronous abort of the partial frame.
- out_valid  out  1  complete frame on col_bits.
- out_ready  in  1  compressor accepts the frame.
- col_bits  out  TOTAL  packed column registers; column i occupies offset sum(h_0..h_{i-1}), newest bit at LSB.
- beat_cnt  out  CW  beats accepted in the current frame.
- frame_cnt  out  FCNT_W  frames handed off, wraps mod 2^FCNT_W.

Behaviour:
- Reset (async, rst_n=0): all column registers 0, beat_cnt 0, frame_cnt 0, state FILL, out_valid 0. in_ready follows the FILL rule and is 1 once reset releases. Reset mid-frame discards the partial frame.
- States:
  - FILL: out_valid=0, in_ready=1.
  - HOLD: out_valid=1, in_ready=out_ready (pass-through acceptance).
- Accepted beat, column i: reg_i <= {reg_i[h_i-2:0], in_bits[i]}; for h_i=1, reg_i <= in_bits[i]. The oldest bit falls off. beat_cnt increments.
- FILL -> HOLD on the accepted beat that makes beat_cnt reach N. beat_cnt holds N in HOLD and col_bits is stable while out_ready=0.
- Handoff (HOLD && out_ready):
  - frame_cnt += 1.
  - If a beat is accepted in the same cycle, it shifts in, beat_cnt becomes 1, and the state is FILL. Otherwise beat_cnt becomes 0 and the state is FILL.
  - Latency: out_valid rises the cycle after the N-th accepted beat. A zero-bubble stream sustains one frame per N cycles.
- flush (FILL only):
  - beat_cnt becomes 0; column registers are retained.
  - A beat accepted in the same cycle is discarded and beat_cnt stays 0.
  - flush is ignored in HOLD.
- Column contents after N beats: column i holds the last h_i beats of in_bits[i]. Bits outside [COLS-1:0] do not exist.

Optional Feature:
- Macro: COLSR_CLEAR_ON_HANDOFF_EN.
- Defined: on handoff, all column registers clear to 0. The only exception is a simultaneously accepted beat, which is loaded into bit 0 of each column (bit 0 = in_bits[i], other bits 0). flush in FILL also clears the registers.
- Undefined: registers retain old bits, which shift out naturally.

Test Plan (N=4: COLS=7, heights 1,2,3,4,3,2,1, TOTAL=16, column 3 at bits 9:6):
- 4 beats of in_bits=7'h7F, out_ready=0 -> out_valid=1 on the cycle after beat 4; col_bits=16'hFFFF; beat_cnt=4; in_ready=0.
- Beats 7'h08,7'h00,7'h00,7'h00 -> col_bits=16'h0200 (column 3 = 4'b1000). Beats 7'h01,0,0,0 -> col_bits=16'h0000 (column 0 keeps only its last beat).
- HOLD with out_ready=0 for 5 cycles and in_valid=1 -> col_bits unchanged, in_ready=0. Then out_ready=1 with in_valid=1 and in_bits=7'h7F -> next cycle out_valid=0, beat_cnt=1, frame_cnt=1.
- After 2 beats pull rst_n low asynchronously (mid-cycle) -> out_valid=0, beat_cnt=0 and col_bits=0 immediately; frame_cnt=0.
- After 3 beats assert flush together with in_valid -> beat_cnt=0. Four further beats are needed before out_valid rises.
- With COLSR_CLEAR_ON_HANDOFF_EN: load all-ones, then handoff with no beat -> col_bits=16'h0000. Without the macro, the same sequence leaves col_bits=16'hFFFF.

Source files
------------

// File: rtl/colsr_frame_loader.sv
// colsr_frame_loader
// Serial front end for the N x N multiplier compressor. Each accepted beat
// shifts one bit into every partial-product column. Column i is h_i bits
// tall, with h_i = min(i+1, 2N-1-i). Once N beats have arrived, the packed
// frame is handed to the compressor through a valid/ready handshake.
//
// Optional build macro: COLSR_CLEAR_ON_HANDOFF_EN
//   defined   - columns clear on handoff and on flush. A beat accepted in
//               the same cycle as the handoff loads into bit 0 only.
//   undefined - columns keep their old bits. Those bits age out as new
//               beats shift in.
//
// Assumes N >= 2.
module colsr_frame_loader #(
  parameter int N      = 26,
  parameter int FCNT_W = 16,
  localparam int COLS  = 2 * N - 1,
  localparam int TOTAL = N * N,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COLS-1:0]   in_bits,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TOTAL-1:0]  col_bits,
  output logic [CW-1:0]     beat_cnt,
  output logic [FCNT_W-1:0] frame_cnt
);

  // Height of column i in the triangular partial-product profile.
  function automatic int col_h(input int i);
    return ((i + 1) < (COLS - i)) ? (i + 1) : (COLS - i);
  endfunction

  // Bit offset of column i inside the packed bus.
  function automatic int col_off(input int i);
    int s;
    s = 0;
    for (int k = 0; k < i; k++) begin
      s = s + col_h(k);
    end
    return s;
  endfunction

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       beat_q, beat_d;
  logic [FCNT_W-1:0]   frame_q, frame_d;
  logic [TOTAL-1:0]    col_q, col_d;

  logic [TOTAL-1:0]    shift_w;
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
  logic [TOTAL-1:0]    load_w;
`endif
  logic                accept_w;

  // Per-column shift-in views.
  // shift_w: every column moves up by one, with in_bits[c] at the LSB.
  // load_w:  a freshly cleared column holding only in_bits[c].
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int H   = col_h(c);
    localparam int OFF = col_off(c);
    if (H == 1) begin : g_h1
      assign shift_w[OFF] = in_bits[c];
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
      assign load_w[OFF]  = in_bits[c];
`endif
    end else begin : g_hn
      assign shift_w[OFF+H-1:OFF] = {col_q[OFF+H-2:OFF], in_bits[c]};
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
      assign load_w[OFF+H-1:OFF]  = {{(H-1){1'b0}}, in_bits[c]};
`endif
    end
  end

  // While in HOLD, acceptance passes straight through from out_ready. A new
  // frame can therefore begin in the same cycle the old one is handed off.
  assign in_ready  = (state_q == ST_FILL) ? 1'b1 : out_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign accept_w  = in_valid && in_ready;

  assign col_bits  = col_q;
  assign beat_cnt  = beat_q;
  assign frame_cnt = frame_q;

  // Next-state logic: fill, flush and handoff.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    frame_d = frame_q;
    col_d   = col_q;
    unique case (state_q)
      ST_FILL: begin
        if (flush) begin
          // A beat arriving in the same cycle as flush is dropped.
          beat_d = '0;
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
          col_d  = '0;
`endif
        end else if (accept_w) begin
          col_d = shift_w;
          if (beat_q == CW'(N - 1)) begin
            beat_d  = CW'(N);
            state_d = ST_HOLD;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        // flush has no effect here. The frame stays stable until out_ready.
        if (out_ready) begin
          frame_d = frame_q + FCNT_W'(1);
          state_d = ST_FILL;
          if (accept_w) begin
            beat_d = CW'(1);
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
            col_d  = load_w;
`else
            col_d  = shift_w;
`endif
          end else begin
            beat_d = '0;
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
            col_d  = '0;
`endif
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State, counter and column registers. Reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      beat_q  <= '0;
      frame_q <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_colsr_frame_loader.sv
// tb_colsr_frame_loader
// Directed and randomized checks of colsr_frame_loader at N=4. Expected
// values come from a reference model kept in the bench: a history queue of
// accepted beats, plus frame bookkeeping derived from the handshake rules.
// Build option: COLSR_CLEAR_ON_HANDOFF_EN selects the clearing variant.
module tb_colsr_frame_loader;

  localparam int N     = 4;
  localparam int COLS  = 7;
  localparam int TOTAL = 16;
  localparam int CW    = 3;
  localparam int FW    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [COLS-1:0]  in_bits;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [TOTAL-1:0] col_bits;
  logic [CW-1:0]    beat_cnt;
  logic [FW-1:0]    frame_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit              m_hold;
  int              m_beat;
  int              m_frame;
  logic [COLS-1:0] hist[$];

  always #5 clk = ~clk;

  colsr_frame_loader #(.N(N), .FCNT_W(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .col_bits  (col_bits),
    .beat_cnt  (beat_cnt),
    .frame_cnt (frame_cnt)
  );

  // Column i holds the most recent h_i history entries, newest at its LSB.
  function automatic logic [TOTAL-1:0] model_cols();
    logic [TOTAL-1:0] r;
    int off, h, n;
    r   = '0;
    off = 0;
    n   = hist.size();
    for (int i = 0; i < COLS; i++) begin
      h = ((i + 1) < (COLS - i)) ? (i + 1) : (COLS - i);
      for (int j = 0; j < h; j++) begin
        if (j < n) r[off + j] = hist[n - 1 - j][i];
      end
      off = off + h;
    end
    return r;
  endfunction

  task automatic push_beat(input logic [COLS-1:0] b);
    hist.push_back(b);
    if (hist.size() > N) void'(hist.pop_front());
  endtask

  task automatic model_reset();
    m_hold  = 1'b0;
    m_beat  = 0;
    m_frame = 0;
    hist.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
    check({tag, ".in_ready"},  32'(in_ready),  32'((!m_hold) || out_ready));
    check({tag, ".beat_cnt"},  32'(beat_cnt),  32'(m_beat));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_frame));
    check({tag, ".col_bits"},  32'(col_bits),  32'(model_cols()));
  endtask

  // Drive one cycle, advance the model, then sample 1 time unit after the edge.
  task automatic step(input bit vld, input logic [COLS-1:0] bits, input bit ordy, input bit fl);
    bit acc;
    in_valid  = vld;
    in_bits   = bits;
    out_ready = ordy;
    flush     = fl;
    acc = vld && (!m_hold || ordy);
    @(posedge clk);
    if (!m_hold) begin
      if (fl) begin
        m_beat = 0;
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
        hist.delete();
`endif
      end else if (acc) begin
        push_beat(bits);
        m_beat++;
        if (m_beat == N) m_hold = 1'b1;
      end
    end else if (ordy) begin
      m_frame = (m_frame + 1) % (1 << FW);
      m_hold  = 1'b0;
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
      hist.delete();
`endif
      if (acc) begin
        push_beat(bits);
        m_beat = 1;
      end else begin
        m_beat = 0;
      end
    end
    #1;
    check_all("step");
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic async_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    check("areset.col_zero",   32'(col_bits),  32'h0);
    check("areset.frame_zero", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bits   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    check("reset.in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Four all-ones beats with the compressor stalled.
    for (int i = 0; i < 4; i++) step(1'b1, 7'h7F, 1'b0, 1'b0);
    check("t1.out_valid", 32'(out_valid), 32'h1);
    check("t1.col_bits",  32'(col_bits),  32'hFFFF);
    check("t1.beat_cnt",  32'(beat_cnt),  32'h4);
    check("t1.in_ready",  32'(in_ready),  32'h0);

    // HOLD under backpressure while beats keep being offered.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7'($urandom), 1'b0, 1'b0);
      check("hold.col_bits", 32'(col_bits), 32'hFFFF);
      check("hold.in_ready", 32'(in_ready), 32'h0);
    end

    // Handoff, with the first beat of the next frame in the same cycle.
    step(1'b1, 7'h7F, 1'b1, 1'b0);
    check("handoff.out_valid", 32'(out_valid), 32'h0);
    check("handoff.beat_cnt",  32'(beat_cnt),  32'h1);
    check("handoff.frame_cnt", 32'(frame_cnt), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 7'($urandom), 1'b0, 1'b0);
    check("refill.out_valid", 32'(out_valid), 32'h1);

    // Column 3 pattern: 08, 00, 00, 00 leaves 4'b1000 at bits 9:6.
    step(1'b1, 7'h08, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 7'h00, 1'b0, 1'b0);
    check("col3.col_bits", 32'(col_bits), 32'h0200);

    // Column 0 keeps only its last beat.
    step(1'b1, 7'h01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 7'h00, 1'b0, 1'b0);
    check("col0.col_bits",  32'(col_bits),  32'h0000);
    check("col0.frame_cnt", 32'(frame_cnt), 32'h3);

    // Partial frame discarded by asynchronous reset.
    step(1'b0, 7'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 7'($urandom), 1'b0, 1'b0);
    check("pre_reset.beat_cnt", 32'(beat_cnt), 32'h2);
    async_reset();

    // flush together with a beat. Four fresh beats are then needed.
    for (int i = 0; i < 3; i++) step(1'b1, 7'($urandom), 1'b0, 1'b0);
    step(1'b1, 7'($urandom), 1'b0, 1'b1);
    check("flush.beat_cnt", 32'(beat_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 7'($urandom), 1'b0, 1'b0);
      check("flush.no_valid", 32'(out_valid), 32'h0);
    end
    step(1'b1, 7'($urandom), 1'b0, 1'b0);
    check("flush.valid", 32'(out_valid), 32'h1);

    // flush has no effect in HOLD.
    step(1'b1, 7'($urandom), 1'b0, 1'b1);
    check("flush_hold.out_valid", 32'(out_valid), 32'h1);

    // All ones, then a handoff with no beat accepted.
    step(1'b0, 7'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 7'h7F, 1'b0, 1'b0);
    step(1'b0, 7'h00, 1'b1, 1'b0);
`ifdef COLSR_CLEAR_ON_HANDOFF_EN
    check("clear.col_bits", 32'(col_bits), 32'h0000);
`else
    check("clear.col_bits", 32'(col_bits), 32'hFFFF);
`endif
    check("clear.beat_cnt", 32'(beat_cnt), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 7'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
